// File: rtl/sfm_norm_ctrl.sv
// Softmax normalisation controller: streams exponentiated vectors through an external
// lane-parallel multiplier against a captured reciprocal, tracking pipeline validity and stalls.
module sfm_norm_ctrl #(
    parameter int DATA_W  = 16,
    parameter int N_LANES = 16,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      start_i,
    input  logic [CNT_W-1:0]          n_vectors_i,
    input  logic                      recip_valid_i,
    input  logic [DATA_W-1:0]         recip_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [N_LANES*DATA_W-1:0] in_data_i,
    output logic                      mul_en_o,
    output logic [N_LANES*DATA_W-1:0] mul_op_a_o,
    output logic [DATA_W-1:0]         mul_op_b_o,
    input  logic [N_LANES*DATA_W-1:0] mul_res_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [N_LANES*DATA_W-1:0] out_data_o,
    output logic                      busy_o,
    output logic                      done_o
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_RECIP = 2'd1,
        ST_NORM       = 2'd2,
        ST_DONE       = 2'd3
    } state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  recip_q;
    logic               recip_loaded_q;
    logic [CNT_W-1:0]   n_vec_q;
    logic [CNT_W-1:0]   issued_q;
    logic [CNT_W-1:0]   retired_q;
    logic [MUL_LAT-1:0] vsr_q;
    logic [MUL_LAT-1:0] vsr_d;

    logic norm_s;
    logic pipe_en_s;
    logic issue_s;
    logic retire_s;
    logic last_retire_s;
    logic recip_cap_s;

    // Pipeline advance, handshakes and next valid-shift-register value.
    always_comb begin
        norm_s        = (state_q == ST_NORM);
        pipe_en_s     = ~vsr_q[MUL_LAT-1] | out_ready_i;
        in_ready_o    = pipe_en_s & norm_s & (issued_q != n_vec_q);
        issue_s       = in_valid_i & in_ready_o;
        retire_s      = norm_s & vsr_q[MUL_LAT-1] & out_ready_i;
        last_retire_s = retire_s & ((retired_q + CNT_W'(1)) == n_vec_q);
        recip_cap_s   = recip_valid_i & ~norm_s;
        vsr_d         = vsr_q << 1;
        vsr_d[0]      = issue_s;
        if (norm_s) begin
            mul_en_o = pipe_en_s;
        end else begin
            mul_en_o = 1'b1;
        end
    end

    assign mul_op_a_o  = in_data_i;
    assign mul_op_b_o  = recip_q;
    assign out_valid_o = vsr_q[MUL_LAT-1];
    assign out_data_o  = mul_res_i;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);

    // Job FSM, reciprocal capture, vector counters and valid tracking.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            recip_q        <= '0;
            recip_loaded_q <= 1'b0;
            n_vec_q        <= '0;
            issued_q       <= '0;
            retired_q      <= '0;
            vsr_q          <= '0;
        end else if (clear_i) begin
            state_q        <= ST_IDLE;
            recip_q        <= '0;
            recip_loaded_q <= 1'b0;
            n_vec_q        <= '0;
            issued_q       <= '0;
            retired_q      <= '0;
            vsr_q          <= '0;
        end else begin
            if (recip_cap_s) begin
                recip_q        <= recip_i;
                recip_loaded_q <= 1'b1;
            end
            if (pipe_en_s) begin
                vsr_q <= vsr_d;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        n_vec_q   <= n_vectors_i;
                        issued_q  <= '0;
                        retired_q <= '0;
                        if (n_vectors_i == '0) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_WAIT_RECIP;
                        end
                    end
                end
                ST_WAIT_RECIP: begin
                    if (recip_loaded_q || recip_valid_i) begin
                        state_q <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (issue_s) begin
                        issued_q <= issued_q + CNT_W'(1);
                    end
                    if (retire_s) begin
                        retired_q <= retired_q + CNT_W'(1);
                    end
                    if (last_retire_s) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A reciprocal arriving in this very cycle is kept for the next job.
                    if (!recip_cap_s) begin
                        recip_loaded_q <= 1'b0;
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfm_norm_ctrl.sv
// Self-checking bench for sfm_norm_ctrl with a behavioural multiplier pipeline and
// per-job expected output lists derived from the stimulus vectors and reciprocal.
module tb_sfm_norm_ctrl;

    localparam int DW = 16;
    localparam int NL = 16;
    localparam int ML = 3;
    localparam int CW = 16;
    localparam int VW = NL * DW;

    logic          clk = 1'b0;
    logic          rst, clear, start, rv, in_valid, in_ready, mul_en, out_valid, out_ready, busy, done;
    logic [CW-1:0] n_vec;
    logic [DW-1:0] recip, op_b;
    logic [VW-1:0] in_data, op_a, mul_res, out_data;

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] vecs[$];
    logic [VW-1:0] got_q[$];
    int first_issue, first_out, first_rdy, last_hs, done_cyc, done_cnt;
    int stall_bad, stall_cyc, opb_bad;
    logic rst_ov, rst_busy, rst_done;

    always #5 clk = ~clk;

    sfm_norm_ctrl #(.DATA_W(DW), .N_LANES(NL), .MUL_LAT(ML), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .n_vectors_i(n_vec),
        .recip_valid_i(rv), .recip_i(recip), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .mul_en_o(mul_en), .mul_op_a_o(op_a), .mul_op_b_o(op_b),
        .mul_res_i(mul_res), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .busy_o(busy), .done_o(done)
    );

    // Stand-in lane operation: any injective function of (x, recip) suffices for the controller.
    function automatic logic [VW-1:0] mulf(input logic [VW-1:0] a, input logic [DW-1:0] b);
        logic [VW-1:0] r;
        for (int l = 0; l < NL; l++) r[l*DW +: DW] = a[l*DW +: DW] ^ (b + DW'(l));
        return r;
    endfunction

    logic [VW-1:0] pipe [ML];
    always @(posedge clk) begin
        if (mul_en) begin
            pipe[0] <= mulf(op_a, op_b);
            for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mul_res = pipe[ML-1];

    task automatic preload(input logic [DW-1:0] v);
        @(posedge clk); #1; rv = 1'b1; recip = v;
        @(posedge clk); #1; rv = 1'b0;
    endtask

    // Runs one job; cycle 0 is the first cycle after the edge that samples start.
    task automatic run_job(input int n, input int rv_at, input logic [DW-1:0] rv_val,
                           input int stall_at, input int stall_len, input int mid_at, input int rst_at);
        int k = 0;
        logic [VW-1:0] prev = '0;
        logic prev_stall = 1'b0;
        logic [VW-1:0] v;
        vecs.delete(); got_q.delete();
        first_issue = -1; first_out = -1; first_rdy = -1; last_hs = -1; done_cyc = -1;
        done_cnt = 0; stall_bad = 0; stall_cyc = 0; opb_bad = 0;
        for (int i = 0; i < n; i++) begin
            for (int l = 0; l < NL; l++) v[l*DW +: DW] = DW'($urandom);
            vecs.push_back(v);
        end
        @(posedge clk); #1; start = 1'b1; n_vec = CW'(n);
        @(posedge clk); #1; start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rv        = (cyc == rv_at) || (cyc == mid_at);
            recip     = (cyc == mid_at) ? 16'h3F00 : rv_val;
            in_valid  = (k < n);
            in_data   = (k < n) ? vecs[k] : '0;
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                rst_ov = out_valid; rst_busy = busy; rst_done = done;
                break;
            end
            if (in_ready && first_rdy < 0) first_rdy = cyc;
            if (in_ready && op_b !== rv_val) opb_bad++;
            if (in_ready && in_valid) begin
                if (first_issue < 0) first_issue = cyc;
                k++;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                if (first_out < 0) first_out = cyc;
                last_hs = cyc;
            end
            if (out_valid && !out_ready) begin
                stall_cyc++;
                if (mul_en !== 1'b0 || in_ready !== 1'b0) stall_bad++;
                if (prev_stall && out_data !== prev) stall_bad++;
                prev = out_data;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
            @(posedge clk); #1;
        end
        rv = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; clear = 1'b0; start = 1'b0; n_vec = '0; rv = 1'b0; recip = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; #1;
        checks++; if ({in_ready, out_valid, done, busy} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {in_ready, out_valid, done, busy}); end
        checks++; if (mul_en !== 1'b1) begin errors++; $display("FAIL reset_mul_en got %b want 1", mul_en); end
        checks++; if (op_b !== 16'h0000) begin errors++; $display("FAIL reset_recip got %h want 0000", op_b); end
    endtask

    task automatic test_preload_n4;
        preload(16'h3E80);
        run_job(4, -1, 16'h3E80, 1000, 0, -1, -1);
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL p4_count got %0d want 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            checks++; if (got_q[i] !== mulf(vecs[i], 16'h3E80)) begin errors++; $display("FAIL p4_data[%0d] got %h want %h", i, got_q[i], mulf(vecs[i], 16'h3E80)); end
        end
        checks++; if (first_out != first_issue + ML) begin errors++; $display("FAIL p4_latency got %0d want %0d", first_out, first_issue + ML); end
        checks++; if (done_cnt != 1 || done_cyc != last_hs + 1) begin errors++; $display("FAIL p4_done got cnt %0d cyc %0d want 1 at %0d", done_cnt, done_cyc, last_hs + 1); end
        checks++; if (opb_bad != 0) begin errors++; $display("FAIL p4_op_b got %0d bad cycles want 0", opb_bad); end
    endtask

    task automatic test_late_recip;
        run_job(2, 5, 16'h3C00, 1000, 0, -1, -1);
        checks++; if (first_rdy != 6) begin errors++; $display("FAIL late_first_ready got %0d want 6", first_rdy); end
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL late_count got %0d want 2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 2; i++) begin
            checks++; if (got_q[i] !== mulf(vecs[i], 16'h3C00)) begin errors++; $display("FAIL late_data[%0d] got %h want %h", i, got_q[i], mulf(vecs[i], 16'h3C00)); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL late_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_stall;
        preload(16'h3D00);
        run_job(8, -1, 16'h3D00, 6, 6, -1, -1);
        checks++; if (stall_cyc != 6) begin errors++; $display("FAIL stall_cycles got %0d want 6", stall_cyc); end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_hold got %0d violations want 0", stall_bad); end
        checks++; if (got_q.size() != 8) begin errors++; $display("FAIL stall_count got %0d want 8", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            checks++; if (got_q[i] !== mulf(vecs[i], 16'h3D00)) begin errors++; $display("FAIL stall_data[%0d] got %h want %h", i, got_q[i], mulf(vecs[i], 16'h3D00)); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_zero;
        run_job(0, -1, 16'h0000, 1000, 0, -1, -1);
        checks++; if (done_cnt != 1 || done_cyc != 0) begin errors++; $display("FAIL zero_done got cnt %0d cyc %0d want 1 at 0", done_cnt, done_cyc); end
        checks++; if (first_rdy != -1) begin errors++; $display("FAIL zero_ready got %0d want -1", first_rdy); end
    endtask

    task automatic test_recip_ignored;
        preload(16'h4000);
        run_job(4, -1, 16'h4000, 1000, 0, 2, -1);
        checks++; if (opb_bad != 0) begin errors++; $display("FAIL ign_op_b got %0d bad cycles want 0", opb_bad); end
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL ign_count got %0d want 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            checks++; if (got_q[i] !== mulf(vecs[i], 16'h4000)) begin errors++; $display("FAIL ign_data[%0d] got %h want %h", i, got_q[i], mulf(vecs[i], 16'h4000)); end
        end
        run_job(2, 4, 16'h3F00, 1000, 0, -1, -1);
        checks++; if (first_rdy != 5) begin errors++; $display("FAIL ign_next_wait got %0d want 5", first_rdy); end
        for (int i = 0; i < got_q.size() && i < 2; i++) begin
            checks++; if (got_q[i] !== mulf(vecs[i], 16'h3F00)) begin errors++; $display("FAIL ign_next_data[%0d] got %h want %h", i, got_q[i], mulf(vecs[i], 16'h3F00)); end
        end
    endtask

    task automatic test_random;
        for (int j = 0; j < 4; j++) begin
            int n = $urandom_range(1, 12);
            int pre = $urandom_range(0, 1);
            int ra = $urandom_range(0, 4);
            int st = $urandom_range(2, 10);
            int sl = $urandom_range(0, 5);
            logic [DW-1:0] val = DW'($urandom);
            if (pre != 0) preload(val);
            run_job(n, (pre != 0) ? -1 : ra, val, st, sl, -1, -1);
            checks++; if (first_rdy != ((pre != 0) ? 1 : ra + 1)) begin errors++; $display("FAIL rnd%0d_first_ready got %0d want %0d", j, first_rdy, (pre != 0) ? 1 : ra + 1); end
            checks++; if (got_q.size() != n) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", j, got_q.size(), n); end
            for (int i = 0; i < got_q.size() && i < n; i++) begin
                checks++; if (got_q[i] !== mulf(vecs[i], val)) begin errors++; $display("FAIL rnd%0d_data[%0d] got %h want %h", j, i, got_q[i], mulf(vecs[i], val)); end
            end
            checks++; if (done_cnt != 1 || done_cyc != last_hs + 1) begin errors++; $display("FAIL rnd%0d_done got cnt %0d cyc %0d want 1 at %0d", j, done_cnt, done_cyc, last_hs + 1); end
            checks++; if (stall_bad != 0) begin errors++; $display("FAIL rnd%0d_stall got %0d violations want 0", j, stall_bad); end
        end
    endtask

    task automatic test_reset_midjob;
        int dn = 0;
        int bz = 0;
        preload(16'h3E00);
        run_job(4, -1, 16'h3E00, 1000, 0, -1, 4);
        checks++; if ({rst_ov, rst_busy, rst_done} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags got %b want 000", {rst_ov, rst_busy, rst_done}); end
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (done) dn++;
            if (busy || out_valid) bz++;
            @(posedge clk); #1;
        end
        checks++; if (dn != 0) begin errors++; $display("FAIL rst_mid_done got %0d pulses want 0", dn); end
        checks++; if (bz != 0) begin errors++; $display("FAIL rst_mid_idle got %0d active cycles want 0", bz); end
    endtask

    initial begin
        test_reset();
        test_preload_n4();
        test_late_recip();
        test_stall();
        test_zero();
        test_recip_ignored();
        test_random();
        test_reset_midjob();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
